// File: rtl/seven_segment_scan_decoder.sv
// seven_segment_scan_decoder: recovers per-digit hex values from a multiplexed active-low 7-seg bus
module seven_segment_scan_decoder #(
  parameter int DIGITS = 4,
  parameter int STABLE_CYCLES = 4
) (
  input  logic                  iClk,
  input  logic                  iReset,
  input  logic                  iEnable,
  input  logic [6:0]            iSegments,
  input  logic [DIGITS-1:0]     iDigitSel,
  output logic [4*DIGITS-1:0]   oValue,
  output logic [DIGITS-1:0]     oDigitValid,
  output logic                  oFrameDone,
  output logic                  oError
);
  logic [6:0] segS, segP;
  logic [DIGITS-1:0] selS, selP, seen, seenNext, commitMask;
  logic [7:0] cnt;
  logic valid, same, commit, hit;
  logic [3:0] glyph;
  always_comb begin
    hit = 1'b1;
    glyph = 4'h0;
    case (segS)
      7'h40: glyph = 4'h0;
      7'h79: glyph = 4'h1;
      7'h24: glyph = 4'h2;
      7'h30: glyph = 4'h3;
      7'h19: glyph = 4'h4;
      7'h12: glyph = 4'h5;
      7'h02: glyph = 4'h6;
      7'h78: glyph = 4'h7;
      7'h00: glyph = 4'h8;
      7'h10: glyph = 4'h9;
      7'h08: glyph = 4'hA;
      7'h03: glyph = 4'hB;
      7'h46: glyph = 4'hC;
      7'h21: glyph = 4'hD;
      7'h06: glyph = 4'hE;
      7'h0E: glyph = 4'hF;
      default: hit = 1'b0;
    endcase
  end
  assign valid = $onehot(~selS);
  assign same = (segS == segP) && (selS == selP);
  // Commit only on the transition into saturation, so a long hold commits once
  assign commit = iEnable && valid && same && (cnt == 8'(STABLE_CYCLES - 1));
  assign commitMask = commit ? ~selS : '0;
  assign seenNext = seen | commitMask;
  always_ff @(posedge iClk or posedge iReset) begin
    if (iReset) begin
      segS <= '0;
      segP <= '0;
      selS <= '0;
      selP <= '0;
      cnt <= '0;
      seen <= '0;
      oValue <= '0;
      oDigitValid <= '0;
      oFrameDone <= 1'b0;
      oError <= 1'b0;
    end else begin
      segS <= iSegments;
      selS <= iDigitSel;
      segP <= segS;
      selP <= selS;
      cnt <= (!iEnable || !valid) ? 8'd0 : !same ? 8'd1 :
             (cnt == 8'(STABLE_CYCLES)) ? cnt : cnt + 8'd1;
      oFrameDone <= &seenNext;
      seen <= (&seenNext) ? '0 : seenNext;
      oError <= commit && !hit && (segS != 7'h7F);
      for (int d = 0; d < DIGITS; d++)
        if (commitMask[d]) begin
          oDigitValid[d] <= hit;
          if (hit) oValue[4*d +: 4] <= glyph;
        end
    end
  end
endmodule

// File: tb/tb_seven_segment_scan_decoder.sv
// tb_seven_segment_scan_decoder: directed checks of the scan decoder, plus a DIGITS=1/STABLE_CYCLES=2 instance
module tb_seven_segment_scan_decoder;
  logic clk = 1'b0, rst = 1'b1, en = 1'b1;
  logic [6:0] seg = 7'h7F, seg1 = 7'h7F;
  logic [3:0] sel = 4'hF;
  logic sel1 = 1'b1;
  logic [15:0] val;
  logic [3:0] dv;
  logic fd, er;
  logic [3:0] val1;
  logic dv1, fd1, er1;
  int checks = 0, failures = 0, fdCnt = 0, erCnt = 0;
  logic [3:0] sels [4] = '{4'hE, 4'hD, 4'hB, 4'h7};
  logic [6:0] pats [4] = '{7'h19, 7'h0E, 7'h40, 7'h21};
  logic [3:0] nibs [4] = '{4'h4, 4'hF, 4'h0, 4'hD};
  logic [6:0] pats1 [4] = '{7'h79, 7'h24, 7'h30, 7'h0E};
  logic [3:0] nibs1 [4] = '{4'h1, 4'h2, 4'h3, 4'hF};

  seven_segment_scan_decoder #(.DIGITS(4), .STABLE_CYCLES(4)) dut (
    .iClk(clk), .iReset(rst), .iEnable(en), .iSegments(seg), .iDigitSel(sel),
    .oValue(val), .oDigitValid(dv), .oFrameDone(fd), .oError(er));
  seven_segment_scan_decoder #(.DIGITS(1), .STABLE_CYCLES(2)) dut1 (
    .iClk(clk), .iReset(rst), .iEnable(1'b1), .iSegments(seg1), .iDigitSel(sel1),
    .oValue(val1), .oDigitValid(dv1), .oFrameDone(fd1), .oError(er1));

  always #5 clk = ~clk;

  task tick();
    @(posedge clk);
    #1;
    if (fd) fdCnt++;
    if (er) erCnt++;
  endtask

  task hold(input logic [3:0] s, input logic [6:0] p, input int n);
    sel = s;
    seg = p;
    repeat (n) tick();
  endtask

  task test_reset();
    tick();
    tick();
    checks++; if (val !== 16'h0 || dv !== 4'h0) begin failures++; $display("FAIL reset_outputs val=%h dv=%b exp 0000/0000", val, dv); end
    checks++; if (fd !== 1'b0 || er !== 1'b0) begin failures++; $display("FAIL reset_pulses fd=%b er=%b exp 0/0", fd, er); end
    checks++; if (val1 !== 4'h0 || dv1 !== 1'b0 || fd1 !== 1'b0) begin failures++; $display("FAIL reset_dut1 val=%h dv=%b fd=%b exp 0/0/0", val1, dv1, fd1); end
    rst = 1'b0;
  endtask

  task test_single();
    hold(4'hE, 7'h24, 4);
    checks++; if (dv !== 4'h0) begin failures++; $display("FAIL single_early dv=%b exp 0000", dv); end
    hold(4'hE, 7'h24, 1);
    checks++; if (dv !== 4'b0001 || val[3:0] !== 4'h2 || fd !== 1'b0) begin failures++; $display("FAIL single_commit dv=%b nib=%h fd=%b exp 0001/2/0", dv, val[3:0], fd); end
    hold(4'hE, 7'h24, 20);
    checks++; if (dv !== 4'b0001 || val !== 16'h0002 || fdCnt != 0 || erCnt != 0) begin failures++; $display("FAIL single_hold dv=%b val=%h fd=%0d er=%0d exp 0001/0002/0/0", dv, val, fdCnt, erCnt); end
  endtask

  task test_scan();
    int f0;
    f0 = fdCnt;
    for (int i = 0; i < 4; i++) begin
      hold(sels[i], pats[i], 4);
      hold(4'hF, 7'h7F, 1);
      checks++; if (val[4*i +: 4] !== nibs[i] || dv[i] !== 1'b1) begin failures++; $display("FAIL scan_digit%0d nib=%h dv=%b exp %h/1", i, val[4*i +: 4], dv[i], nibs[i]); end
      checks++; if (fd !== (i == 3)) begin failures++; $display("FAIL scan_frame%0d fd=%b exp %b", i, fd, i == 3); end
    end
    checks++; if (val !== 16'hD0F4 || dv !== 4'hF || fdCnt - f0 != 1) begin failures++; $display("FAIL scan_final val=%h dv=%b frames=%0d exp D0F4/1111/1", val, dv, fdCnt - f0); end
  endtask

  task test_glitch();
    hold(4'hE, 7'h30, 3);
    hold(4'hE, 7'h79, 1);
    hold(4'hE, 7'h30, 3);
    checks++; if (val[3:0] !== 4'h4) begin failures++; $display("FAIL glitch_nocommit nib=%h exp 4", val[3:0]); end
    hold(4'hE, 7'h30, 1);
    checks++; if (val[3:0] !== 4'h4) begin failures++; $display("FAIL glitch_third nib=%h exp 4", val[3:0]); end
    hold(4'hF, 7'h7F, 1);
    checks++; if (val !== 16'hD0F3 || dv !== 4'hF) begin failures++; $display("FAIL glitch_commit val=%h dv=%b exp D0F3/1111", val, dv); end
  endtask

  task test_invalid_blank_error();
    int e0;
    e0 = erCnt;
    hold(4'hC, 7'h24, 10);
    hold(4'hF, 7'h24, 10);
    checks++; if (val !== 16'hD0F3 || dv !== 4'hF || erCnt != e0) begin failures++; $display("FAIL invalid_sel val=%h dv=%b err=%0d exp D0F3/1111/%0d", val, dv, erCnt, e0); end
    hold(4'hD, 7'h7F, 4);
    hold(4'hF, 7'h7F, 1);
    checks++; if (dv !== 4'b1101 || val !== 16'hD0F3 || erCnt != e0) begin failures++; $display("FAIL blank dv=%b val=%h err=%0d exp 1101/D0F3/%0d", dv, val, erCnt, e0); end
    hold(4'hB, 7'h55, 4);
    hold(4'hF, 7'h7F, 1);
    checks++; if (er !== 1'b1 || dv !== 4'b1001 || val !== 16'hD0F3) begin failures++; $display("FAIL error_commit er=%b dv=%b val=%h exp 1/1001/D0F3", er, dv, val); end
    hold(4'hF, 7'h7F, 1);
    checks++; if (er !== 1'b0 || erCnt - e0 != 1) begin failures++; $display("FAIL error_pulse er=%b pulses=%0d exp 0/1", er, erCnt - e0); end
  endtask

  task test_enable();
    int f0;
    f0 = fdCnt;
    hold(4'h7, 7'h02, 2);
    en = 1'b0;
    hold(4'h7, 7'h02, 10);
    checks++; if (val !== 16'hD0F3 || dv !== 4'b1001 || fdCnt != f0) begin failures++; $display("FAIL disabled_hold val=%h dv=%b frames=%0d exp D0F3/1001/0", val, dv, fdCnt - f0); end
    en = 1'b1;
    hold(4'h7, 7'h02, 3);
    checks++; if (val !== 16'hD0F3) begin failures++; $display("FAIL reenable_early val=%h exp D0F3", val); end
    hold(4'h7, 7'h02, 1);
    checks++; if (val !== 16'h60F3 || dv !== 4'b1001 || fd !== 1'b1) begin failures++; $display("FAIL reenable_commit val=%h dv=%b fd=%b exp 60F3/1001/1", val, dv, fd); end
  endtask

  task test_reset_midhold();
    hold(4'hE, 7'h00, 2);
    rst = 1'b1;
    #1;
    checks++; if (val !== 16'h0 || dv !== 4'h0 || fd !== 1'b0 || er !== 1'b0) begin failures++; $display("FAIL async_reset val=%h dv=%b fd=%b er=%b exp 0", val, dv, fd, er); end
    tick();
    rst = 1'b0;
    hold(4'hE, 7'h00, 4);
    checks++; if (dv !== 4'h0) begin failures++; $display("FAIL post_reset_early dv=%b exp 0000", dv); end
    hold(4'hF, 7'h7F, 1);
    checks++; if (dv !== 4'b0001 || val !== 16'h0008) begin failures++; $display("FAIL post_reset_commit dv=%b val=%h exp 0001/0008", dv, val); end
  endtask

  task test_back_to_back();
    sel1 = 1'b0;
    for (int i = 0; i < 4; i++) begin
      seg1 = pats1[i];
      tick();
      if (i > 0) begin
        checks++; if (val1 !== nibs1[i-1] || dv1 !== 1'b1 || fd1 !== 1'b1) begin failures++; $display("FAIL sweep_commit%0d val=%h dv=%b fd=%b exp %h/1/1", i, val1, dv1, fd1, nibs1[i-1]); end
      end else begin
        checks++; if (fd1 !== 1'b0) begin failures++; $display("FAIL sweep_start fd=%b exp 0", fd1); end
      end
      tick();
      checks++; if (fd1 !== 1'b0) begin failures++; $display("FAIL sweep_gap%0d fd=%b exp 0", i, fd1); end
    end
    sel1 = 1'b1;
    tick();
    checks++; if (val1 !== 4'hF || fd1 !== 1'b1 || er1 !== 1'b0) begin failures++; $display("FAIL sweep_last val=%h fd=%b er=%b exp F/1/0", val1, fd1, er1); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_scan();
    test_glitch();
    test_invalid_blank_error();
    test_enable();
    test_reset_midhold();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
